// File: rtl/xc_aes_pkg.sv
// Shared AES definitions for the aessub functional unit and its checker: FSM states,
// operand lane selection, packing rotate and the forward/inverse S-box functions.
package xc_aes_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} aes_state_e;

  // Lane i always takes byte i; odd lanes come from rs2, even lanes from rs1.
  localparam logic [3:0]  LaneFromRs2 = 4'b1010;
  localparam int unsigned RotAmt      = 8;

  function automatic logic [7:0] lane_byte(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [1:0] lane);
    logic [31:0] src;
    src = LaneFromRs2[lane] ? rs2 : rs1;
    return src[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] gather_lanes(input logic [31:0] rs1, input logic [31:0] rs2);
    return {lane_byte(rs1, rs2, 2'd3), lane_byte(rs1, rs2, 2'd2),
            lane_byte(rs1, rs2, 2'd1), lane_byte(rs1, rs2, 2'd0)};
  endfunction

  function automatic logic [31:0] pack_word(input logic [31:0] w, input logic rot);
    return rot ? ((w << RotAmt) | (w >> (32 - RotAmt))) : w;
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] aes_sbox_fwd(input logic [7:0] x);
    return aes_affine(gf_inv(x));
  endfunction

  function automatic logic [7:0] aes_sbox_inv(input logic [7:0] x);
    return gf_inv(aes_inv_affine(x));
  endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combined forward/inverse AES S-box sharing one GF(2^8) inverter between directions.
module xc_aes_sbox
  import xc_aes_pkg::*;
(
  input  logic       enc_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  always_comb begin
    inv_in  = enc_i ? byte_i : aes_inv_affine(byte_i);
    inv_out = gf_inv(inv_in);
    byte_o  = enc_i ? aes_affine(inv_out) : inv_out;
  end

endmodule

// File: rtl/xc_aessub_fu.sv
// XCrypto xc.aessub execute-stage unit: iterative one-S-box datapath by default,
// or a single-cycle four-S-box datapath when XC_AESSUB_FAST_EN is defined.
module xc_aessub_fu
  import xc_aes_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] result
);

  aes_state_e  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        rot_q, rot_d;
  logic [31:0] lanes;

  assign lanes = gather_lanes(rs1, rs2);

  // Bytes of rs1/rs2 that never feed a lane.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

`ifdef XC_AESSUB_FAST_EN
  logic [31:0] fast_word;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    xc_aes_sbox u_sbox (
      .enc_i  (enc),
      .byte_i (lanes[8*i +: 8]),
      .byte_o (fast_word[8*i +: 8])
    );
  end
`else
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] ops_q, ops_d;   // lanes 1..3, consumed from the bottom byte
  logic        enc_q, enc_d;
  logic        sbox_enc;
  logic [7:0]  sbox_in, sbox_out;

  xc_aes_sbox u_sbox (
    .enc_i  (sbox_enc),
    .byte_i (sbox_in),
    .byte_o (sbox_out)
  );
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rot_d   = rot_q;
    ready   = 1'b0;
    result  = 32'h0;
`ifndef XC_AESSUB_FAST_EN
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    enc_d    = enc_q;
    sbox_enc = enc_q;
    sbox_in  = ops_q[7:0];
`endif
    unique case (state_q)
      StIdle: begin
`ifndef XC_AESSUB_FAST_EN
        sbox_enc = enc;
        sbox_in  = lanes[7:0];
`endif
        if (valid && !flush) begin
          rot_d = rot;
`ifdef XC_AESSUB_FAST_EN
          acc_d   = fast_word;
          state_d = StDone;
`else
          enc_d   = enc;
          ops_d   = lanes[31:8];
          acc_d   = {24'h0, sbox_out};
          cnt_d   = 2'd1;
          state_d = StBusy;
`endif
        end
      end
      StBusy: begin
`ifndef XC_AESSUB_FAST_EN
        if (!valid) begin
          state_d = StIdle;
          cnt_d   = 2'd0;
        end else begin
          acc_d[{cnt_q, 3'b000} +: 8] = sbox_out;
          ops_d = {8'h00, ops_q[23:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StDone;
            cnt_d   = 2'd0;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        state_d = StIdle;
        if (!flush) begin
          ready  = 1'b1;
          result = pack_word(acc_q, rot_q);
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
`ifndef XC_AESSUB_FAST_EN
      cnt_d = 2'd0;
`endif
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      acc_q   <= 32'h0;
      rot_q   <= 1'b0;
`ifndef XC_AESSUB_FAST_EN
      cnt_q   <= 2'd0;
      ops_q   <= 24'h0;
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rot_q   <= rot_d;
`ifndef XC_AESSUB_FAST_EN
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      enc_q   <= enc_d;
`endif
    end
  end

  nbytes_fixed_a: assert property (@(posedge g_clk) disable iff (!g_resetn) NBYTES == 4);

endmodule

// File: tb/tb_xc_aessub_fu.sv
// Directed, table-driven bench for xc_aessub_fu; expected latencies follow XC_AESSUB_FAST_EN.
module tb_xc_aessub_fu;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic [31:0] exp;
  } vec_t;

`ifdef XC_AESSUB_FAST_EN
  localparam int Lat = 1;
  localparam int FlushCyc = 0;
`else
  localparam int Lat = 4;
  localparam int FlushCyc = 2;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn, flush, valid, enc, rot;
  logic [31:0] rs1, rs2;
  logic        ready;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  vec_t vecs[9];

  xc_aessub_fu #(.NBYTES(4)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (flush),
    .valid    (valid),
    .rs1      (rs1),
    .rs2      (rs2),
    .enc      (enc),
    .rot      (rot),
    .ready    (ready),
    .result   (result)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rs1 = v.rs1;
    rs2 = v.rs2;
    enc = v.enc;
    rot = v.rot;
  endtask

  task automatic run_op(input vec_t v, input bit scramble, input string name);
    int lat;
    logic [31:0] got;
    int leak;
    @(posedge g_clk); #1;
    apply(v);
    valid = 1'b1;
    lat = -1;
    got = 32'h0;
    leak = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge g_clk);
      if (ready) begin
        lat = k;
        got = result;
        break;
      end
      if (result !== 32'h0) leak = 1;
      if (scramble && k == 1) begin
        rs1 = ~v.rs1;
        rs2 = ~v.rs2;
        enc = ~v.enc;
        rot = ~v.rot;
      end
    end
    @(posedge g_clk); #1;
    valid = 1'b0;
    check_int({name, " latency"}, lat, Lat);
    check32({name, " result"}, got, v.exp);
    check_int({name, " result nonzero while not ready"}, leak, 0);
  endtask

  task automatic reset_at(input int cyc, input string name);
    int seen;
    @(posedge g_clk); #1;
    apply(vecs[0]);
    valid = 1'b1;
    for (int k = 0; k < cyc; k++) begin
      @(posedge g_clk); #1;
    end
    #1 g_resetn = 1'b0;
    #1;
    check32({name, " ready/result in reset"}, {31'h0, ready} | result, 32'h0);
    valid = 1'b0;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge g_clk);
      if (ready) seen = 1;
    end
    check_int({name, " ready after reset"}, seen, 0);
  endtask

  initial begin
    int seen;
    int p0, p1, npulse;
    logic [31:0] r0, r1, snap;

    vecs[0] = '{32'h00530001, 32'h00000000, 1'b1, 1'b0, 32'h63ed637c};
    vecs[1] = '{32'h00530001, 32'h00000000, 1'b1, 1'b1, 32'hed637c63};
    vecs[2] = '{32'h00ed007c, 32'h63006300, 1'b0, 1'b1, 32'h53000100};
    vecs[3] = '{32'h00ed007c, 32'h63006300, 1'b0, 1'b0, 32'h00530001};
    vecs[4] = '{32'h00ff0002, 32'h1000fe00, 1'b1, 1'b0, 32'hca16bb77};
    vecs[5] = '{32'h00ff0002, 32'h1000fe00, 1'b1, 1'b1, 32'h16bb77ca};
    vecs[6] = '{32'h00160077, 32'hca00bb00, 1'b0, 1'b0, 32'h10fffe02};
    vecs[7] = '{32'hab40cd80, 32'h20aa0199, 1'b1, 1'b0, 32'hb7097ccd};
    vecs[8] = '{32'h550966cd, 32'hb7337c44, 1'b0, 1'b1, 32'h40018020};

    g_resetn = 1'b0;
    flush = 1'b0;
    valid = 1'b0;
    rs1 = 32'h0;
    rs2 = 32'h0;
    enc = 1'b0;
    rot = 1'b0;
    @(negedge g_clk);
    check32("reset ready", {31'h0, ready}, 32'h0);
    check32("reset result", result, 32'h0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check32("post-reset ready/result", {31'h0, ready} | result, 32'h0);

    for (int i = 0; i < 9; i++) run_op(vecs[i], (i % 2) == 1, $sformatf("vec%0d", i));

    // Flush while the operation is in flight.
    @(posedge g_clk); #1;
    apply(vecs[0]);
    valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge g_clk); #1;
      end
      flush = (k == FlushCyc);
      if (k > FlushCyc) valid = 1'b0;
      @(negedge g_clk);
      if (ready) seen = 1;
    end
    flush = 1'b0;
    check_int("flush mid-op ready", seen, 0);
    run_op(vecs[1], 1'b0, "post-flush");

    // Flush coinciding with the DONE cycle suppresses the pulse.
    @(posedge g_clk); #1;
    apply(vecs[2]);
    valid = 1'b1;
    seen = 0;
    snap = 32'hffffffff;
    for (int k = 0; k < Lat + 4; k++) begin
      if (k > 0) begin
        @(posedge g_clk); #1;
      end
      flush = (k == Lat);
      if (k > Lat) valid = 1'b0;
      @(negedge g_clk);
      if (ready) seen = 1;
      if (k == Lat) snap = result;
    end
    flush = 1'b0;
    check_int("flush at done ready", seen, 0);
    check32("flush at done result", snap, 32'h0);
    run_op(vecs[3], 1'b0, "post-flush-done");

`ifndef XC_AESSUB_FAST_EN
    // Dropping valid while busy aborts the operation.
    @(posedge g_clk); #1;
    apply(vecs[4]);
    valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge g_clk); #1;
      end
      if (k >= 2) valid = 1'b0;
      @(negedge g_clk);
      if (ready) seen = 1;
    end
    check_int("abort ready", seen, 0);
    run_op(vecs[5], 1'b0, "post-abort");
`endif

    reset_at(2, "reset cycle2");
    run_op(vecs[6], 1'b0, "post-reset2");
    reset_at(Lat, "reset at done");
    run_op(vecs[7], 1'b0, "post-reset-done");

    // Back-to-back: valid held high across two operations.
    @(posedge g_clk); #1;
    apply(vecs[0]);
    valid = 1'b1;
    npulse = 0;
    p0 = -1;
    p1 = -1;
    r0 = 32'h0;
    r1 = 32'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge g_clk);
      if (ready) begin
        if (npulse == 0) begin
          p0 = k;
          r0 = result;
          apply(vecs[8]);
        end else begin
          p1 = k;
          r1 = result;
        end
        npulse++;
        if (npulse == 2) break;
      end
    end
    @(posedge g_clk); #1;
    valid = 1'b0;
    check_int("b2b first pulse cycle", p0, Lat);
    check_int("b2b pulse spacing", p1 - p0, Lat + 1);
    check32("b2b first result", r0, vecs[0].exp);
    check32("b2b second result", r1, vecs[8].exp);

    repeat (3) @(posedge g_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xc_aessub_fu.md
Name: xc_aessub_fu

Overview:
- Execute-stage functional unit that computes the XCrypto xc.aessub.{enc,encrot,dec,decrot} result inside the core.
- Its output is the rd write data that the formal instruction models compare against the combinational aessub checker.
- Multi-cycle, area-lean: one shared forward/inverse AES S-box, iterated over four bytes under a small FSM with a valid/ready handshake to the execute stage.

Parameters:
- NBYTES, 4, bytes processed per operation; fixed at 4, present for assertions only.

Ports:
- g_clk  input  1  core clock.
- g_resetn  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush; abandons any in-flight operation.
- valid  input  1  operation request. Held with operands until ready, or until flush.
- rs1  input  32  source register 1.
- rs2  input  32  source register 2.
- enc  input  1  1 = forward S-box (encrypt), 0 = inverse S-box (decrypt).
- rot  input  1  1 = rotate the packed result.
- ready  output  1  single-cycle pulse; result is valid in the same cycle.
- result  output  32  packed substituted word.

Behaviour:
- Reset (async assert, sync release): state IDLE, byte counter 0, ready 0, result 0, operand and accumulator registers 0.
- Byte selection (decided):
  - t0 = rs1[7:0], t1 = rs2[15:8], t2 = rs1[23:16], t3 = rs2[31:24].
  - si = S(ti), where S is the forward S-box if enc=1, otherwise the inverse S-box.
- Packing:
  - rot=0: result = {s3,s2,s1,s0}.
  - rot=1: result = {s2,s1,s0,s3}, i.e. rotate left by 8.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when valid && !flush, latch rs1, rs2, enc and rot, compute s0 from the live rs1, write s0 into accumulator byte 0, set cnt=1, go to BUSY.
  - BUSY: each cycle compute s[cnt] from the latched operands, write it into accumulator byte cnt, then cnt++. When cnt==3 is written, go to DONE.
  - DONE: ready=1 and result = packed accumulator for exactly this one cycle, then go to IDLE. result returns to 0 whenever ready=0.
- Latency: valid first seen in cycle 0 gives ready in cycle 4. Back-to-back requests: if valid is still high in the cycle after DONE, it is a new request. Minimum initiation interval is 5 cycles.
- flush in any state: next state IDLE, cnt=0, no ready pulse. flush has priority over a new valid in IDLE. If flush coincides with DONE, ready is suppressed in that cycle.
- valid dropping while in BUSY is treated as an abort: return to IDLE with no ready.
- Operand changes while BUSY are ignored because the latched copies are used.
- Reset asserted mid-operation: immediate return to the reset values; no ready is ever produced for the aborted request.
- Counter is 2 bits. The BUSY→DONE transition is taken at cnt==3, so the counter never wraps during an operation.

Optional Feature:
- Macro: XC_AESSUB_FAST_EN.
- Defined:
  - Four S-box instances; the result is computed combinationally from the live operands.
  - The FSM is reduced to IDLE and DONE. valid in cycle 0 gives a registered ready plus result in cycle 1, with the same flush and abort rules.
- Undefined: the iterative 4-cycle datapath above.
- The result value is bit-identical in both builds; only latency differs.

Decomposition:
- Shared package xc_aes_pkg:
  - FSM state enum (IDLE, BUSY, DONE).
  - Byte-lane select constants (which source register and byte feeds t0..t3).
  - Rotate-amount constant.
  - Forward and inverse S-box tables as constant functions, reused by the checker.
- Sub-module xc_aes_sbox: combinational 8-bit in, 8-bit out, enc select.

Test Plan:
- Encrypt: enc=1 rot=0 rs1=0x00530001 rs2=0x00000000 → ready in cycle 4, result=0x63ed637c.
- Encrypt-rot: same operands with rot=1 → result=0xed637c63.
- Decrypt-rot: enc=0 rot=1 rs1=0x00ed007c rs2=0x63006300 → result=0x53000100. The same operands with rot=0 → result=0x00530001.
- Flush: start an operation, assert flush in cycle 2 → no ready pulse, FSM is in IDLE in cycle 3. Then a fresh valid completes normally 4 cycles later.
- Reset mid-op: assert g_resetn low in cycle 2 → ready=0 and result=0 immediately. A post-release request gives the correct result.
- Back-to-back: hold valid high across two operations with different operands → two ready pulses 5 cycles apart, each with the correct result. Run with XC_AESSUB_FAST_EN as well; expect pulses 2 cycles apart.
